// File: rtl/ir_select_decoder.sv
// Register-select decoder: latches the IR, picks Ra/Rb/Rc on request and drives one-hot enables.
// Optional macro SELENC_R0_ZERO_EN: ba_out on R0 drives zero_out instead of r_out_en.
module ir_select_decoder #(
  parameter int NREGS = 16,
  parameter int CW    = 19
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [31:0]      ir_in,
  input  logic             ir_ld,
  input  logic             req,
  input  logic             gra,
  input  logic             grb,
  input  logic             grc,
  input  logic             r_in,
  input  logic             r_out,
  input  logic             ba_out,
  output logic [NREGS-1:0] r_in_en,
  output logic [NREGS-1:0] r_out_en,
  output logic             zero_out,
  output logic [31:0]      c_sext,
  output logic [4:0]       opcode,
  output logic             ack,
  output logic             sel_err,
  output logic             load_err
);

  localparam int IW = $clog2(NREGS);

  typedef enum logic [1:0] {IDLE, DECODE, HOLD} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      ir;
  logic [2:0]       sel_q;
  logic             r_in_q;
  logic             r_out_q;
  logic             ba_q;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    field;
  logic             sel_ok;
  logic [NREGS-1:0] idx_hot;
  logic [NREGS-1:0] in_en_d;
  logic [NREGS-1:0] out_en_d;
  logic             zero_d;
  logic             ack_d;

  assign sel_ok  = $onehot({gra, grb, grc});
  assign c_sext  = {{(32-CW){ir[CW-1]}}, ir[CW-1:0]};
  assign opcode  = ir[31:27];
  assign idx_hot = {{(NREGS-1){1'b0}}, 1'b1} << idx;

  always_comb begin
    case (sel_q)
      3'b100:  field = ir[26 -: IW];
      3'b010:  field = ir[22 -: IW];
      default: field = ir[18 -: IW];
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req && sel_ok) state_nxt = DECODE;
      DECODE:  state_nxt = HOLD;
      HOLD:    if (!req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // IR, selector and flags only move in IDLE so a request sees a stable instruction.
  always_ff @(posedge clk) begin
    if (clr) begin
      ir       <= '0;
      sel_q    <= '0;
      r_in_q   <= 1'b0;
      r_out_q  <= 1'b0;
      ba_q     <= 1'b0;
      idx      <= '0;
      sel_err  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      if (ir_ld && state == IDLE) ir <= ir_in;
      if (ir_ld && state != IDLE) load_err <= 1'b1;
      sel_err <= (state == IDLE) && req && !sel_ok;
      if (state == IDLE && req && sel_ok) begin
        sel_q   <= {gra, grb, grc};
        r_in_q  <= r_in;
        r_out_q <= r_out;
        ba_q    <= ba_out;
      end
      if (state == DECODE) idx <= field;
    end
  end

  always_comb begin
    in_en_d  = '0;
    out_en_d = '0;
    zero_d   = 1'b0;
    ack_d    = 1'b0;
    if (state == HOLD && req) begin
      ack_d = 1'b1;
      if (r_in_q) in_en_d = idx_hot;
`ifdef SELENC_R0_ZERO_EN
      if (ba_q && idx == '0) zero_d = 1'b1;
      else if (r_out_q || ba_q) out_en_d = idx_hot;
`else
      if (r_out_q || ba_q) out_en_d = idx_hot;
`endif
    end
  end

  // Registered enables give the extra edge of latency and a one-edge release.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_in_en  <= '0;
      r_out_en <= '0;
      zero_out <= 1'b0;
      ack      <= 1'b0;
    end else begin
      r_in_en  <= in_en_d;
      r_out_en <= out_en_d;
      zero_out <= zero_d;
      ack      <= ack_d;
    end
  end

endmodule
